num_check: RTL

NUM_CHECK -- requirements
Module: num_check

---
 rtl/num_pkg.sv | 21 ++
 rtl/lfsr_en.sv | 28 ++
 rtl/num_check.sv | 122 ++++++++++++
 3 files changed

// File: rtl/num_pkg.sv
// Shared types and constants for the stream number checker.
// Holds the FSM states, error flag bit positions and LFSR taps.
package num_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  localparam int ERR_DATA  = 0;
  localparam int ERR_PAD   = 1;
  localparam int ERR_DEST  = 2;
  localparam int ERR_TLAST = 3;

  localparam int TAP_A = 7;
  localparam int TAP_B = 5;
  localparam int TAP_C = 4;
  localparam int TAP_D = 3;

endpackage

// File: rtl/lfsr_en.sv
// Enabled LFSR step with synchronous seed load.
// Produces the expected payload sequence for the checker.
module lfsr_en #(
  parameter int             W    = 8,
  parameter logic [W-1:0]   SEED = 8'h01
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         en,
  output logic [W-1:0] q
);
  import num_pkg::*;

  logic fb;
  assign fb = q[TAP_A] ^ q[TAP_B] ^ q[TAP_C] ^ q[TAP_D];

  // Seed on reset/load, otherwise shift left one step per enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      q <= SEED;
    else if (load)
      q <= SEED;
    else if (en)
      q <= {q[W-2:0], fb};
  end

endmodule

// File: rtl/num_check.sv
// AXI-Stream sink that checks payloads against an LFSR sequence.
// Reports sticky error flags, error beat and packet counts.
module num_check #(
  parameter int                TDATAW      = 32,
  parameter int                TDESTW      = 4,
  parameter int                TIDW        = 2,
  parameter int                LFSR_DW     = 7,
  parameter logic [LFSR_DW:0]  LFSR_SEED   = 8'h01,
  parameter int                PKT_LEN     = 1,
  parameter int                NUM_PACKETS = 1,
  parameter int                EXP_DEST    = 1
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              START,
  input  logic              STALL,
  input  logic              AXIS_S_TVALID,
  output logic              AXIS_S_TREADY,
  input  logic [TDATAW-1:0] AXIS_S_TDATA,
  input  logic              AXIS_S_TLAST,
  input  logic [TIDW-1:0]   AXIS_S_TID,
  input  logic [TDESTW-1:0] AXIS_S_TDEST,
  output logic              DONE,
  output logic              PASS,
  output logic [3:0]        ERR_FLAGS,
  output logic [15:0]       ERR_CNT,
  output logic [8:0]        PKT_CNT
);
  import num_pkg::*;

  localparam logic [LFSR_DW:0] SEED =
    (LFSR_SEED == '0) ? {{LFSR_DW{1'b0}}, 1'b1} : LFSR_SEED;
  localparam logic [7:0] LAST_IDX = 8'(PKT_LEN - 1);
  localparam logic [8:0] LAST_PKT = 9'(NUM_PACKETS - 1);

  state_t           state;
  state_t           state_nxt;
  logic [7:0]       beat_cnt;
  logic [LFSR_DW:0] expected;
  logic [LFSR_DW:0] payload;
  logic             run_go;
  logic             accept;
  logic             final_pkt;
  logic [3:0]       beat_err;
  logic             tid_unused;

  assign tid_unused = ^AXIS_S_TID;

  assign payload       = AXIS_S_TDATA[LFSR_DW:0];
  assign run_go        = START & (state != S_RUN);
  assign AXIS_S_TREADY = (state == S_RUN) & ~STALL;
  assign accept        = AXIS_S_TVALID & AXIS_S_TREADY;
  assign final_pkt     = AXIS_S_TLAST & (PKT_CNT == LAST_PKT);
  assign DONE          = (state == S_DONE);
  assign PASS          = DONE & (ERR_CNT == 16'h0000);

  lfsr_en #(
    .W    (LFSR_DW + 1),
    .SEED (SEED)
  ) u_lfsr (
    .clk   (CLK),
    .rst_n (RST_N),
    .load  (run_go),
    .en    (accept),
    .q     (expected)
  );

  // Classify the current beat against every check.
  always_comb begin
    beat_err = 4'b0000;
    beat_err[ERR_DATA]  = (payload != expected);
    beat_err[ERR_PAD]   = ((AXIS_S_TDATA >> (LFSR_DW + 1)) != '0);
    beat_err[ERR_DEST]  = (AXIS_S_TDEST != TDESTW'(EXP_DEST));
    beat_err[ERR_TLAST] = AXIS_S_TLAST ? (beat_cnt != LAST_IDX)
                                       : (beat_cnt >= LAST_IDX);
  end

  // Run control: START arms a run, the last packet's TLAST ends it.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: if (START) state_nxt = S_RUN;
      S_RUN:  if (accept && final_pkt) state_nxt = S_DONE;
      S_DONE: if (START) state_nxt = S_RUN;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  // Counters and sticky flags; cleared on run start, frozen outside RUN.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ERR_FLAGS <= 4'b0000;
      ERR_CNT   <= 16'h0000;
      PKT_CNT   <= 9'd0;
      beat_cnt  <= 8'd0;
    end else if (run_go) begin
      ERR_FLAGS <= 4'b0000;
      ERR_CNT   <= 16'h0000;
      PKT_CNT   <= 9'd0;
      beat_cnt  <= 8'd0;
    end else if (accept) begin
      ERR_FLAGS <= ERR_FLAGS | beat_err;
      if ((beat_err != 4'b0000) && (ERR_CNT != 16'hFFFF))
        ERR_CNT <= ERR_CNT + 16'd1;
      if (AXIS_S_TLAST) begin
        beat_cnt <= 8'd0;
        PKT_CNT  <= PKT_CNT + 9'd1;
      end else if (beat_cnt != 8'hFF) begin
        beat_cnt <= beat_cnt + 8'd1;
      end
    end
  end

endmodule
